// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - pipelined barrel shifter/rotator with valid/ready backpressure
// log2(WIDTH) mux levels are spread over STAGES register stages; results stay in order.
module pipe_shifter #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int L   = $clog2(WIDTH);
  localparam int PER = (L + STAGES - 1) / STAGES;

  // Applies mux levels lo..hi-1; SRA fill uses the original operand MSB.
  function automatic logic [WIDTH-1:0] shift_levels(
    input logic [WIDTH-1:0] d,
    input logic [SHW-1:0]   sh,
    input logic [2:0]       mode,
    input logic             msb,
    input int               lo,
    input int               hi
  );
    logic [WIDTH-1:0] r;
    logic [SHW-1:0]   bitk;
    int               a;
    r = d;
    for (int k = 0; k < L; k++) begin
      a    = 1 << k;
      bitk = SHW'(1) << k;
      if (k >= lo && k < hi && (sh & bitk) != '0) begin
        case (mode)
          3'b000:  r = r << a;
          3'b001:  r = r >> a;
          3'b010:  r = (r >> a) | ({WIDTH{msb}} << (WIDTH - a));
          3'b011:  r = (r << a) | (r >> (WIDTH - a));
          3'b100:  r = (r >> a) | (r << (WIDTH - a));
          default: r = r;
        endcase
      end
    end
    return r;
  endfunction

  logic [STAGES:0] rdy;
  logic            init_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= 1'b1;
  end

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0] & init_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = (s * PER < L) ? s * PER : L;
    localparam int HI = ((s + 1) * PER < L) ? (s + 1) * PER : L;

    logic             up_valid;
    logic             up_msb;
    logic [WIDTH-1:0] up_data;
    logic [SHW-1:0]   up_shamt;
    logic [2:0]       up_mode;
    logic [WIDTH-1:0] nxt_data;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    if (s == 0) begin : g_src
      assign up_valid = in_valid & init_q;
      assign up_data  = in_data;
      assign up_shamt = in_shamt;
      assign up_mode  = in_mode;
      assign up_msb   = in_data[WIDTH-1];
    end else begin : g_src
      assign up_valid = g_stage[s-1].valid_q;
      assign up_data  = g_stage[s-1].data_q;
      assign up_shamt = g_stage[s-1].g_side.shamt_q;
      assign up_mode  = g_stage[s-1].g_side.mode_q;
      assign up_msb   = g_stage[s-1].g_side.msb_q;
    end

    assign rdy[s]   = !valid_q | rdy[s+1];
    assign nxt_data = shift_levels(up_data, up_shamt, up_mode, up_msb, LO, HI);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (rdy[s]) begin
        valid_q <= up_valid;
        if (up_valid) data_q <= nxt_data;
      end
    end

    if (s < STAGES - 1) begin : g_side
      logic [SHW-1:0] shamt_q;
      logic [2:0]     mode_q;
      logic           msb_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shamt_q <= '0;
          mode_q  <= '0;
          msb_q   <= 1'b0;
        end else if (rdy[s] && up_valid) begin
          shamt_q <= up_shamt;
          mode_q  <= up_mode;
          msb_q   <= up_msb;
        end
      end
    end else begin : g_tail
      // Zero flag is registered with the result so it needs no compare on the output path.
      logic zero_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  zero_q <= 1'b0;
        else if (rdy[s] && up_valid) zero_q <= (nxt_data == '0);
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign out_data  = g_stage[STAGES-1].data_q & {WIDTH{out_valid}};
  assign out_zero  = g_stage[STAGES-1].g_tail.zero_q & out_valid;

endmodule

// File: tb/tb_pipe_shifter.sv
// tb/tb_pipe_shifter.sv - scoreboard bench for pipe_shifter
// Directed vectors, throughput/latency, backpressure, random traffic and mid-flight reset.
module tb_pipe_shifter;

  localparam int ST = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;

  logic        x_rstn, x_valid, x_oready;
  logic [31:0] x_data;
  logic [4:0]  x_shamt;
  logic [2:0]  x_mode;
  logic        s1_ready, s1_valid, s1_zero, s5_ready, s5_valid, s5_zero;
  logic [31:0] s1_data, s5_data;

  logic or_force, rnd_en, rnd_bit, b2b_en, lat_en;
  assign out_ready = rnd_en ? rnd_bit : or_force;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  logic [31:0] exp_q[$];
  int          acc_q[$];

  pipe_shifter #(.WIDTH(32), .STAGES(ST)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero)
  );

  pipe_shifter #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(x_rstn), .in_valid(x_valid), .in_ready(s1_ready),
    .in_data(x_data), .in_shamt(x_shamt), .in_mode(x_mode),
    .out_valid(s1_valid), .out_ready(x_oready), .out_data(s1_data), .out_zero(s1_zero)
  );

  pipe_shifter #(.WIDTH(32), .STAGES(5)) u_s5 (
    .clk(clk), .rst_n(x_rstn), .in_valid(x_valid), .in_ready(s5_ready),
    .in_data(x_data), .in_shamt(x_shamt), .in_mode(x_mode),
    .out_valid(s5_valid), .out_ready(x_oready), .out_data(s5_data), .out_zero(s5_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [31:0] d, input logic [4:0] sh,
                                         input logic [2:0] m);
    logic [31:0] r;
    case (m)
      3'd0: r = d << sh;
      3'd1: r = d >> sh;
      3'd2: r = $signed(d) >>> sh;
      3'd3: r = (sh == 0) ? d : ((d << sh) | (d >> (6'd32 - {1'b0, sh})));
      3'd4: r = (sh == 0) ? d : ((d >> sh) | (d << (6'd32 - {1'b0, sh})));
      default: r = d;
    endcase
    return r;
  endfunction

  // Transfers are decided at the negedge before the edge they happen on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stale_out", out_valid, 0);
        end else begin
          check("out_data", out_data, exp_q[0]);
          check("out_zero", out_zero, exp_q[0] == 0);
          if (out_ready) begin
            if (lat_en) check("latency", cyc - acc_q[0], ST);
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            pops++;
          end
        end
      end else begin
        check("idle_data", out_data, 0);
      end
    end
  end

  initial begin
    rnd_bit = 1'b0;
    forever begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] m,
                      input logic [31:0] e);
    int  waits;
    bit  ok;
    in_valid = 1'b1; in_data = d; in_shamt = sh; in_mode = m;
    ok = 0; waits = 0;
    while (!ok && waits < 1000) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else waits++;
    end
    if (!ok) check("send_timeout", in_ready, 1);
    else begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      if (b2b_en) check("b2b_in_ready", waits, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_d[4];
  logic [4:0]  bp_s[4];
  logic [2:0]  bp_m[4];

  initial begin
    int acc, n, pops0, f1, f5;
    logic [31:0] d;
    logic [4:0]  sh;
    logic [2:0]  m;
    rst_n = 1'b0; x_rstn = 1'b0;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0;
    x_valid = 1'b0; x_data = '0; x_shamt = '0; x_mode = '0; x_oready = 1'b1;
    or_force = 1'b1; rnd_en = 1'b0; b2b_en = 1'b0; lat_en = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_zero", out_zero, 0);
    @(negedge clk);
    rst_n = 1'b1; x_rstn = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1);
    check("s1_rel_ready", s1_ready, 1);
    check("s5_rel_ready", s5_ready, 1);

    // STAGES=1 and STAGES=5 instances: reset with two ops in flight.
    x_valid = 1'b1; x_data = 32'h8000_0000; x_shamt = 5'd4; x_mode = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    x_rstn = 1'b0; x_valid = 1'b0;
    #1;
    check("s1_rst_valid", s1_valid, 0);
    check("s1_rst_data", s1_data, 0);
    check("s5_rst_valid", s5_valid, 0);
    check("s5_rst_data", s5_data, 0);
    @(negedge clk); x_rstn = 1'b1;
    @(posedge clk); #1;
    check("s1_ready_after", s1_ready, 1);
    check("s5_ready_after", s5_ready, 1);
    repeat (6) begin
      @(negedge clk);
      check("s1_no_stale", s1_valid, 0);
      check("s5_no_stale", s5_valid, 0);
    end
    @(posedge clk); #1;
    x_valid = 1'b1; x_data = 32'h1234_5678; x_shamt = 5'd8; x_mode = 3'd4;
    @(posedge clk); #1;
    x_valid = 1'b0;
    f1 = -1; f5 = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s1_valid && f1 < 0) begin f1 = i; check("s1_data", s1_data, 32'h7812_3456); end
      if (s5_valid && f5 < 0) begin f5 = i; check("s5_data", s5_data, 32'h7812_3456); end
    end
    check("s1_latency", f1, 0);
    check("s5_latency", f5, 4);
    @(posedge clk); #1;

    // Directed vectors back to back with full throughput.
    b2b_en = 1'b1; lat_en = 1'b1;
    send(32'h8000_0000, 5'd4,  3'd2, 32'hF800_0000);
    send(32'h8000_0000, 5'd4,  3'd1, 32'h0800_0000);
    send(32'h0000_0001, 5'd31, 3'd0, 32'h8000_0000);
    send(32'h1234_5678, 5'd8,  3'd4, 32'h7812_3456);
    send(32'h8000_0001, 5'd1,  3'd3, 32'h0000_0003);
    send(32'h1234_5678, 5'd0,  3'd4, 32'h1234_5678);
    send(32'hDEAD_BEEF, 5'd5,  3'd7, 32'hDEAD_BEEF);
    send(32'h0000_000F, 5'd4,  3'd1, 32'h0000_0000);
    b2b_en = 1'b0;
    drain();
    lat_en = 1'b0;

    // Backpressure: a stalled 2-stage pipe takes exactly two ops.
    bp_d[0] = 32'hA5A5_0F0F; bp_s[0] = 5'd3;  bp_m[0] = 3'd3;
    bp_d[1] = 32'h8765_4321; bp_s[1] = 5'd17; bp_m[1] = 3'd2;
    bp_d[2] = 32'h0F00_00F0; bp_s[2] = 5'd12; bp_m[2] = 3'd0;
    bp_d[3] = 32'hCAFE_F00D; bp_s[3] = 5'd9;  bp_m[3] = 3'd4;
    or_force = 1'b0;
    pops0 = pops;
    acc = 0;
    in_valid = 1'b1; in_data = bp_d[0]; in_shamt = bp_s[0]; in_mode = bp_m[0];
    n = 0;
    while (acc < 4 && n < 60) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_op(bp_d[acc], bp_s[acc], bp_m[acc]));
        acc_q.push_back(cyc);
        acc++;
      end
      @(posedge clk); #1;
      n++;
      if (acc < 4) begin
        in_data = bp_d[acc]; in_shamt = bp_s[acc]; in_mode = bp_m[acc];
      end else begin
        in_valid = 1'b0;
      end
      if (n == 6) begin
        check("bp_accepted", acc, 2);
        check("bp_in_ready", in_ready, 0);
        or_force = 1'b1;
      end
    end
    in_valid = 1'b0;
    drain();
    check("bp_popped", pops - pops0, 4);

    // Random traffic against the reference model.
    rnd_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      d  = $urandom;
      sh = 5'($urandom_range(0, 31));
      m  = 3'($urandom_range(0, 7));
      send(d, sh, m, ref_op(d, sh, m));
    end
    rnd_en = 1'b0; or_force = 1'b1;
    drain();

    // Main instance: reset with two ops in flight.
    send(32'h0000_00FF, 5'd4, 3'd0, 32'h0000_0FF0);
    send(32'h0000_0000, 5'd4, 3'd1, 32'h0000_0000);
    rst_n = 1'b0;
    exp_q.delete(); acc_q.delete();
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_zero", out_zero, 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_ready", in_ready, 1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    send(32'hF000_0000, 5'd28, 3'd2, 32'hFFFF_FFFF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
